// File: rtl/wb_pkg.sv
// wb_pkg: shared arbiter types and priority helpers (state enum, one-hot to index, round-robin masking, priority pick)
package wb_pkg;
  typedef enum logic [1:0] {IDLE, OWNED, ABORT} arb_state_e;
  localparam int MAX_PORTS = 16;
  function automatic logic [3:0] oh2idx(input logic [MAX_PORTS-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) if (oh[i]) idx |= 4'(i);
    return idx;
  endfunction
  // ports strictly after `last` in priority order, limited to the n real ports
  function automatic logic [MAX_PORTS-1:0] mask_after(input logic [3:0] last, input int n, input bit lsb_hi);
    logic [MAX_PORTS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PORTS; i++) m[i] = (i < n) && (lsb_hi ? (i > int'(last)) : (i < int'(last)));
    return m;
  endfunction
  function automatic logic [MAX_PORTS-1:0] prio_pick(input logic [MAX_PORTS-1:0] req, input bit lsb_hi);
    logic [MAX_PORTS-1:0] g;
    g = '0;
    for (int i = 0; i < MAX_PORTS; i++) if (req[i] && (!lsb_hi || g == '0)) g = MAX_PORTS'(1) << i;
    return g;
  endfunction
endpackage

// File: rtl/wb_arbiter_rr_n_if.sv
// wb_arbiter_rr_n_if: N-master / 1-slave Wishbone classic bundle
//   wbm_*   : packed per-master request slices in, responses out (dat_o broadcast)
//   wbs_*   : single slave-side request out, response in
//   grant_o : one-hot owner, timeout_o : watchdog pulse
interface wb_arbiter_rr_n_if #(
  parameter int PORTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [PORTS*ADDR_WIDTH-1:0] wbm_adr_i;
  logic [PORTS*DATA_WIDTH-1:0] wbm_dat_i;
  logic [PORTS*SELECT_WIDTH-1:0] wbm_sel_i;
  logic [PORTS-1:0] wbm_we_i, wbm_stb_i, wbm_cyc_i;
  logic [DATA_WIDTH-1:0] wbm_dat_o;
  logic [PORTS-1:0] wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [ADDR_WIDTH-1:0] wbs_adr_o;
  logic [DATA_WIDTH-1:0] wbs_dat_o;
  logic [SELECT_WIDTH-1:0] wbs_sel_o;
  logic wbs_we_o, wbs_stb_o, wbs_cyc_o;
  logic [DATA_WIDTH-1:0] wbs_dat_i;
  logic wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic [PORTS-1:0] grant_o;
  logic timeout_o;
  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_stb_i, wbm_cyc_i,
    input wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o, timeout_o
  );
  modport slave (
    input wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_stb_o, wbs_cyc_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );
  modport arb (
    input wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_stb_i, wbm_cyc_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_stb_o, wbs_cyc_o,
    input wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output grant_o, timeout_o
  );
endinterface

// File: rtl/wb_rr_prio_sel.sv
// wb_rr_prio_sel: combinational masked priority encoder
//   i_req : requests, i_last : one-hot last owner, i_rr : 1 = round-robin, 0 = fixed
//   o_grant : one-hot winner, o_valid : any request present
module wb_rr_prio_sel
  import wb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int LSB_HI = 1
) (
  input  logic [PORTS-1:0] i_req,
  input  logic [PORTS-1:0] i_last,
  input  logic             i_rr,
  output logic [PORTS-1:0] o_grant,
  output logic             o_valid
);
  logic [MAX_PORTS-1:0] w_req, w_msk;
  assign w_req = MAX_PORTS'(i_req);
  assign w_msk = i_rr ? w_req & mask_after(oh2idx(MAX_PORTS'(i_last)), PORTS, LSB_HI != 0) : '0;
  // requests beyond the last owner win; otherwise wrap to plain priority
  assign o_grant = PORTS'(prio_pick(|w_msk ? w_msk : w_req, LSB_HI != 0));
  assign o_valid = |i_req;
endmodule

// File: rtl/wb_arbiter_rr_n.sv
// wb_arbiter_rr_n: N-master to 1-slave Wishbone classic arbiter/mux with watchdog
//   clk, rst_n : clock, asynchronous active-low reset
//   io_bus     : wb_arbiter_rr_n_if.arb (master requests/responses, slave side, grant_o, timeout_o)
module wb_arbiter_rr_n
  import wb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int ARB_ROUND_ROBIN = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 1,
  parameter int TIMEOUT = 0
) (
  input logic clk,
  input logic rst_n,
  wb_arbiter_rr_n_if.arb io_bus
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  // abort is registered, so expiry is taken one count early to land ERR on waiting cycle TIMEOUT
  localparam int EXP = TIMEOUT > 1 ? TIMEOUT - 2 : 0;
  localparam logic [PORTS-1:0] LAST_RST = PORTS'(1) << (PORTS - 1);
  arb_state_e r_state;
  logic [PORTS-1:0] r_grant, r_last, w_win;
  logic [CW-1:0] r_cnt;
  logic w_valid, w_own_cyc, w_own_stb, w_we, w_resp, w_owned, w_abort, w_wait, w_expire;
  logic [ADDR_WIDTH-1:0] w_adr;
  logic [DATA_WIDTH-1:0] w_dat;
  logic [SELECT_WIDTH-1:0] w_sel;
  wb_rr_prio_sel #(.PORTS(PORTS), .LSB_HI(ARB_LSB_HIGH_PRIORITY)) u_sel (
    .i_req(io_bus.wbm_cyc_i),
    .i_last(r_last),
    .i_rr(ARB_ROUND_ROBIN != 0),
    .o_grant(w_win),
    .o_valid(w_valid)
  );
  // one-hot grant makes an AND-OR mux; zero grant yields all-zero slave outputs
  always_comb begin
    w_adr = '0;
    w_dat = '0;
    w_sel = '0;
    w_we = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      if (r_grant[k]) begin
        w_adr |= io_bus.wbm_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_dat |= io_bus.wbm_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel |= io_bus.wbm_sel_i[k*SELECT_WIDTH +: SELECT_WIDTH];
        w_we |= io_bus.wbm_we_i[k];
      end
    end
  end
  assign w_own_cyc = |(r_grant & io_bus.wbm_cyc_i);
  assign w_own_stb = |(r_grant & io_bus.wbm_stb_i);
  assign w_owned = r_state == OWNED;
  assign w_abort = r_state == ABORT;
  assign w_resp = io_bus.wbs_ack_i | io_bus.wbs_err_i | io_bus.wbs_rty_i;
  assign w_wait = (TIMEOUT > 0) && w_own_stb && !w_resp;
  assign w_expire = r_cnt == CW'(EXP);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last <= LAST_RST;
      r_cnt <= '0;
    end else if (!w_own_cyc) begin
      r_cnt <= '0;
      r_state <= w_valid ? OWNED : IDLE;
      r_grant <= w_valid ? w_win : '0;
      if (w_valid) r_last <= w_win;
    end else if (w_abort || !w_wait) begin
      r_state <= OWNED;
      r_cnt <= '0;
    end else if (w_expire) begin
      r_state <= ABORT;
      r_cnt <= '0;
    end else
      r_cnt <= r_cnt + 1'b1;
  assign io_bus.wbs_adr_o = w_adr;
  assign io_bus.wbs_dat_o = w_dat;
  assign io_bus.wbs_sel_o = w_sel;
  assign io_bus.wbs_we_o = w_we;
  assign io_bus.wbs_cyc_o = w_owned & w_own_cyc;
  assign io_bus.wbs_stb_o = w_owned & w_own_stb;
  assign io_bus.wbm_dat_o = io_bus.wbs_dat_i;
  assign io_bus.wbm_ack_o = r_grant & {PORTS{io_bus.wbs_ack_i}};
  assign io_bus.wbm_rty_o = r_grant & {PORTS{io_bus.wbs_rty_i}};
  // a late slave response during the abort cycle still wins over the forced error
  assign io_bus.wbm_err_o = r_grant & {PORTS{io_bus.wbs_err_i | (w_abort & ~w_resp)}};
  assign io_bus.timeout_o = w_abort & ~w_resp;
  assign io_bus.grant_o = r_grant;
endmodule
